// File: rtl/sys_pkg.sv
// Shared constants, loader state type and counter-width helpers
// for the systolic weight loader.
package sys_pkg;

  localparam int SYS_N  = 4;
  localparam int SYS_DW = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } ld_state_e;

  function automatic int wr_cnt_w(input int n);
    return $clog2(n * n + 1);
  endfunction

  function automatic int t_w(input int n);
    return $clog2(2 * n);
  endfunction

endpackage

// File: rtl/sys_weight_bank.sv
// N x N weight register bank: one row/col write port and
// N read ports, read port c returning the selected row of column c.
module sys_weight_bank #(
  parameter int N  = 4,
  parameter int DW = 16
) (
  input  logic                    clk,
  input  logic                    i_we,
  input  logic [$clog2(N)-1:0]    i_wrow,
  input  logic [$clog2(N)-1:0]    i_wcol,
  input  logic [DW-1:0]           i_wdata,
  input  logic [N*$clog2(N)-1:0]  i_rrow,
  output logic [N*DW-1:0]         o_rdata
);

  localparam int RW = $clog2(N);

  logic [DW-1:0] r_mem [N][N];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_wrow][i_wcol] <= i_wdata;
  end

  always_comb begin
    o_rdata = '0;
    for (int c = 0; c < N; c++) begin
      o_rdata[c*DW +: DW] = r_mem[i_rrow[c*RW +: RW]][c];
    end
  end

endmodule

// File: rtl/sys_weight_loader.sv
// Double-buffered weight loader with skewed column streaming.
// Macro SYS_WLOAD_TRANSPOSE_EN selects column-major (transposed) loading.
module sys_weight_loader
  import sys_pkg::*;
#(
  parameter int N  = SYS_N,
  parameter int DW = SYS_DW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic [DW-1:0]   in,
  output logic            in_ready,
  input  logic            swap,
  output logic            pass,
  output logic [N*DW-1:0] out,
  output logic [N-1:0]    out_vld,
  output logic            done_w,
  output logic            shadow_full
);

  localparam int RW     = $clog2(N);
  localparam int WCW    = wr_cnt_w(N);
  localparam int TW     = t_w(N);
  localparam int LAST_T = 2 * N - 2;
  localparam int CELLS  = N * N;

  logic [WCW-1:0]  r_wr_cnt;
  logic            r_full;
  logic            r_bank;
  ld_state_e       r_state;
  logic [TW-1:0]   r_t;
  logic            r_pass;
  logic            r_done;
  logic [N-1:0]    r_vld;
  logic [N*DW-1:0] r_out;

  logic            w_wr_en;
  logic            w_swap_ok;
  logic [RW-1:0]   w_wrow;
  logic [RW-1:0]   w_wcol;
  ld_state_e       w_nstate;
  logic [TW-1:0]   w_nt;
  logic            w_nbank;
  logic [N*RW-1:0] w_raddr;
  logic [N-1:0]    w_nvld;
  logic [N*DW-1:0] w_rd0;
  logic [N*DW-1:0] w_rd1;
  logic [N*DW-1:0] w_rsel;
  logic [N*DW-1:0] w_nout;

  assign w_wr_en   = load && !r_full;
  assign w_swap_ok = swap && r_full && (r_state == ST_IDLE);

`ifdef SYS_WLOAD_TRANSPOSE_EN
  assign w_wrow = RW'(r_wr_cnt % WCW'(N));
  assign w_wcol = RW'(r_wr_cnt / WCW'(N));
`else
  assign w_wrow = RW'(r_wr_cnt / WCW'(N));
  assign w_wcol = RW'(r_wr_cnt % WCW'(N));
`endif

  always_comb begin
    w_nstate = r_state;
    w_nt     = r_t;
    unique case (r_state)
      ST_IDLE: begin
        if (w_swap_ok) begin
          w_nstate = ST_STREAM;
          w_nt     = '0;
        end
      end
      ST_STREAM: begin
        if (r_t == TW'(LAST_T)) w_nstate = ST_DONE;
        else                    w_nt     = r_t + 1'b1;
      end
      ST_DONE: w_nstate = ST_IDLE;
      default: w_nstate = ST_IDLE;
    endcase
  end

  assign w_nbank = w_swap_ok ? ~r_bank : r_bank;

  // Column c lags by c cycles; bottom row leaves first
  always_comb begin
    w_raddr = '0;
    w_nvld  = '0;
    for (int c = 0; c < N; c++) begin
      if (w_nstate == ST_STREAM &&
          int'(w_nt) >= c && int'(w_nt) < c + N) begin
        w_nvld[c]           = 1'b1;
        w_raddr[c*RW +: RW] = RW'(N - 1 + c - int'(w_nt));
      end
    end
  end

  sys_weight_bank #(.N(N), .DW(DW)) u_bank0 (
    .clk     (clk),
    .i_we    (w_wr_en && r_bank),
    .i_wrow  (w_wrow),
    .i_wcol  (w_wcol),
    .i_wdata (in),
    .i_rrow  (w_raddr),
    .o_rdata (w_rd0)
  );

  sys_weight_bank #(.N(N), .DW(DW)) u_bank1 (
    .clk     (clk),
    .i_we    (w_wr_en && !r_bank),
    .i_wrow  (w_wrow),
    .i_wcol  (w_wcol),
    .i_wdata (in),
    .i_rrow  (w_raddr),
    .o_rdata (w_rd1)
  );

  assign w_rsel = w_nbank ? w_rd1 : w_rd0;

  always_comb begin
    w_nout = '0;
    for (int c = 0; c < N; c++) begin
      if (w_nvld[c]) w_nout[c*DW +: DW] = w_rsel[c*DW +: DW];
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_wr_cnt <= '0;
      r_full   <= 1'b0;
      r_bank   <= 1'b0;
      r_state  <= ST_IDLE;
      r_t      <= '0;
      r_pass   <= 1'b0;
      r_done   <= 1'b0;
      r_vld    <= '0;
      r_out    <= '0;
    end else begin
      if (w_wr_en) begin
        if (r_wr_cnt == WCW'(CELLS - 1)) begin
          r_wr_cnt <= '0;
          r_full   <= 1'b1;
        end else begin
          r_wr_cnt <= r_wr_cnt + 1'b1;
        end
      end
      if (w_swap_ok) r_full <= 1'b0;
      r_bank  <= w_nbank;
      r_state <= w_nstate;
      r_t     <= w_nt;
      r_pass  <= (w_nstate == ST_STREAM);
      r_done  <= (w_nstate == ST_DONE);
      r_vld   <= w_nvld;
      r_out   <= w_nout;
    end
  end

  assign in_ready    = !r_full;
  assign shadow_full = r_full;
  assign pass        = r_pass;
  assign done_w      = r_done;
  assign out_vld     = r_vld;
  assign out         = r_out;

endmodule

// File: tb/tb_sys_weight_loader.sv
// Self-checking bench for sys_weight_loader against a tile-level model.
// Honours SYS_WLOAD_TRANSPOSE_EN in the model's load mapping.
module tb_sys_weight_loader;

  localparam int N  = 4;
  localparam int DW = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            load;
  logic [DW-1:0]   din;
  logic            in_ready;
  logic            swap;
  logic            pass;
  logic [N*DW-1:0] out;
  logic [N-1:0]    out_vld;
  logic            done_w;
  logic            shadow_full;

  always #5 clk = ~clk;

  sys_weight_loader #(.N(N), .DW(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (load),
    .in          (din),
    .in_ready    (in_ready),
    .swap        (swap),
    .pass        (pass),
    .out         (out),
    .out_vld     (out_vld),
    .done_w      (done_w),
    .shadow_full (shadow_full)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Tile-level model: shadow/active tiles, fill count, stream start edge
  logic [DW-1:0] m_sh [N][N];
  logic [DW-1:0] m_ac [N][N];
  bit m_full;
  int m_cnt;
  int m_start;
  int m_ok;
  int e;

  task automatic model_edge();
    int r, c;
    bit acc;
    e++;
    if (rst_n) begin
      m_full  = 0;
      m_cnt   = 0;
      m_start = -1000;
      m_ok    = 0;
    end else begin
      acc = swap && m_full && (e >= m_ok);
      if (load && !m_full) begin
`ifdef SYS_WLOAD_TRANSPOSE_EN
        r = m_cnt % N;
        c = m_cnt / N;
`else
        r = m_cnt / N;
        c = m_cnt % N;
`endif
        m_sh[r][c] = din;
        m_cnt++;
        if (m_cnt == N * N) begin
          m_cnt  = 0;
          m_full = 1;
        end
      end else if (acc) begin
        m_ac    = m_sh;
        m_full  = 0;
        m_start = e;
        m_ok    = e + 2 * N + 1;
      end
    end
  endtask

  task automatic compare();
    int p, d;
    bit ep;
    logic [N-1:0] ev;
    logic [N*DW-1:0] eo;
    p  = e - m_start;
    ep = (p >= 0) && (p <= 2 * N - 2);
    ev = '0;
    eo = '0;
    for (int c = 0; c < N; c++) begin
      d = p - c;
      if (ep && d >= 0 && d < N) begin
        ev[c] = 1'b1;
        eo[c*DW +: DW] = m_ac[N-1-d][c];
      end
    end
    chk("pass", 64'(pass), 64'(ep));
    chk("out_vld", 64'(out_vld), 64'(ev));
    chk("out", 64'(out), 64'(eo));
    chk("done_w", 64'(done_w), 64'(p == 2 * N - 1));
    chk("in_ready", 64'(in_ready), 64'(!m_full));
    chk("shadow_full", 64'(shadow_full), 64'(m_full));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  initial begin
    e = 0;
    m_start = -1000;
    rst_n = 1'b1;
    load  = 1'b0;
    swap  = 1'b0;
    din   = '0;
    step();
    step();
    rst_n = 1'b0;

    swap = 1'b1;
    step();
    step();
    swap = 1'b0;

    // 17 words: the last one must be dropped
    for (int i = 0; i < 17; i++) begin
      load = 1'b1;
      din  = DW'(i);
      step();
    end
    load = 1'b0;
    swap = 1'b1;
    step();
    swap = 1'b0;

    // Tile B loads while A streams; stray swaps meanwhile
    for (int i = 0; i < 16; i++) begin
      load = 1'b1;
      din  = DW'(100 + i);
      swap = 1'(($urandom % 2));
      step();
    end
    load = 1'b0;
    swap = 1'b1;
    repeat (20) step();
    swap = 1'b0;

    // Abort at t=3
    for (int i = 0; i < 16; i++) begin
      load = 1'b1;
      din  = DW'($urandom);
      step();
    end
    load = 1'b0;
    swap = 1'b1;
    step();
    swap = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    rst_n = 1'b0;
    repeat (10) step();

    for (int i = 0; i < 800; i++) begin
      load  = ($urandom % 4) != 0;
      din   = DW'($urandom);
      swap  = ($urandom % 3) == 0;
      rst_n = ($urandom % 150) == 0;
      step();
    end
    rst_n = 1'b0;
    load  = 1'b0;
    swap  = 1'b0;
    repeat (12) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
